// File: rtl/regfile_write_arbiter_if.sv
// Register-file write port bundle: two requesters, clear control and the
// registered write outputs that feed the register file.
interface regfile_write_arbiter_if #(
  parameter int data_width   = 32,
  parameter int select_width = 5
);
  logic                    req0_valid;
  logic [select_width-1:0] req0_addr;
  logic [data_width-1:0]   req0_data;
  logic                    req0_ready;
  logic                    req1_valid;
  logic [select_width-1:0] req1_addr;
  logic [data_width-1:0]   req1_data;
  logic                    req1_ready;
  logic                    clear_start;
  logic                    clear_busy;
  logic [data_width-1:0]   write_data;
  logic [select_width-1:0] write_address;
  logic                    RegWrite;

  // Requester / register-file side
  modport master (
    output req0_valid, req0_addr, req0_data,
    input  req0_ready,
    output req1_valid, req1_addr, req1_data,
    input  req1_ready,
    output clear_start,
    input  clear_busy,
    input  write_data, write_address, RegWrite
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_addr, req0_data,
    output req0_ready,
    input  req1_valid, req1_addr, req1_data,
    output req1_ready,
    input  clear_start,
    output clear_busy,
    output write_data, write_address, RegWrite
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Two-requester round-robin write arbiter for a register file, with a
// bulk-clear sequencer that zeroes every register one per cycle.
// Write outputs are registered: an accepted request appears one cycle later.
module regfile_write_arbiter #(
  parameter int data_width   = 32,
  parameter int select_width = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  regfile_write_arbiter_if.slave  bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam logic [select_width-1:0] LAST_ADDR = '1;
  localparam logic [select_width-1:0] ONE       = {{(select_width-1){1'b0}}, 1'b1};

  state_t                  r_state, w_state_nxt;
  logic                    r_ptr, w_ptr_nxt;
  logic [select_width-1:0] r_cnt, w_cnt_nxt;
  logic                    r_we, w_we_nxt;
  logic [select_width-1:0] r_addr, w_addr_nxt;
  logic [data_width-1:0]   r_data, w_data_nxt;

  logic w_arb_en;
  logic w_grant0;
  logic w_grant1;

  // Arbitration is only open in IDLE when no clear is being requested;
  // reset closes it so nothing is accepted on a reset edge.
  assign w_arb_en = !rst && (r_state == IDLE) && !bus.clear_start;

  // A lone requester wins outright; under contention the pointer decides.
  assign w_grant0 = w_arb_en && bus.req0_valid && (!bus.req1_valid || !r_ptr);
  assign w_grant1 = w_arb_en && bus.req1_valid && (!bus.req0_valid ||  r_ptr);

  assign bus.req0_ready    = w_grant0;
  assign bus.req1_ready    = w_grant1;
  assign bus.clear_busy    = (r_state == CLEAR);
  assign bus.RegWrite      = r_we;
  assign bus.write_address = r_addr;
  assign bus.write_data    = r_data;

  // Next-state and next-output logic; address/data hold when not writing.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_we_nxt    = 1'b0;
    w_addr_nxt  = r_addr;
    w_data_nxt  = r_data;
    unique case (r_state)
      IDLE: begin
        if (bus.clear_start) begin
          w_state_nxt = CLEAR;
          w_cnt_nxt   = '0;
        end else if (w_grant0) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = bus.req0_addr;
          w_data_nxt = bus.req0_data;
          w_ptr_nxt  = 1'b1;
        end else if (w_grant1) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = bus.req1_addr;
          w_data_nxt = bus.req1_data;
          w_ptr_nxt  = 1'b0;
        end
      end
      CLEAR: begin
        // clear_start is deliberately ignored here; the sweep runs to the end.
        w_we_nxt   = 1'b1;
        w_addr_nxt = r_cnt;
        w_data_nxt = '0;
        w_cnt_nxt  = r_cnt + ONE;
        if (r_cnt == LAST_ADDR) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers; reset abandons any clear in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= 1'b0;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_we    <= w_we_nxt;
      r_addr  <= w_addr_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Grants are mutually exclusive by construction.
  a_one_hot_ready: assert property (@(posedge clk) !(bus.req0_ready && bus.req1_ready));

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus a randomized run,
// all checked against a transaction-level model (writes-remaining counter
// for clears, favoured-requester bit for arbitration).
module tb_regfile_write_arbiter;
  localparam int DW    = 32;
  localparam int SW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  regfile_write_arbiter_if #(.data_width(DW), .select_width(SW)) bus();

  regfile_write_arbiter #(.data_width(DW), .select_width(SW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int              m_clr_left = 0;
  bit              m_ptr      = 1'b0;
  bit              m_we       = 1'b0;
  logic [SW-1:0]   m_addr     = '0;
  logic [DW-1:0]   m_data     = '0;
  bit              tg0, tg1;

  function automatic void exp_grant(output bit g0, output bit g1);
    g0 = 1'b0;
    g1 = 1'b0;
    if (!(rst || m_clr_left > 0 || bus.clear_start)) begin
      if (bus.req0_valid && bus.req1_valid) begin
        g0 = !m_ptr;
        g1 = m_ptr;
      end else begin
        g0 = bus.req0_valid;
        g1 = bus.req1_valid;
      end
    end
  endfunction

  task automatic drive(input bit r, input bit v0, input logic [SW-1:0] a0, input logic [DW-1:0] d0,
                       input bit v1, input logic [SW-1:0] a1, input logic [DW-1:0] d1, input bit cs);
    rst             = r;
    bus.req0_valid  = v0;
    bus.req0_addr   = a0;
    bus.req0_data   = d0;
    bus.req1_valid  = v1;
    bus.req1_addr   = a1;
    bus.req1_data   = d1;
    bus.clear_start = cs;
  endtask

  // Advance one clock; the model computes what the edge should produce.
  task automatic tick();
    bit g0, g1;
    exp_grant(g0, g1);
    tg0 = g0;
    tg1 = g1;
    if (rst) begin
      m_clr_left = 0; m_ptr = 1'b0; m_we = 1'b0; m_addr = '0; m_data = '0;
    end else if (m_clr_left > 0) begin
      m_we = 1'b1; m_addr = SW'(DEPTH - m_clr_left); m_data = '0;
      m_clr_left--;
    end else if (bus.clear_start) begin
      m_clr_left = DEPTH; m_we = 1'b0;
    end else if (g0) begin
      m_we = 1'b1; m_addr = bus.req0_addr; m_data = bus.req0_data; m_ptr = 1'b1;
    end else if (g1) begin
      m_we = 1'b1; m_addr = bus.req1_addr; m_data = bus.req1_data; m_ptr = 1'b0;
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 5'd4, 32'hdead, 1, 5'd6, 32'hbeef, 1);
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    tick();
    vectors++;
    if ({bus.RegWrite, bus.clear_busy, bus.write_address, bus.write_data} !== {1'b0, 1'b0, 5'd0, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b busy=%b addr=%h data=%h expected all zero",
               bus.RegWrite, bus.clear_busy, bus.write_address, bus.write_data);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    vectors++;
    if ({bus.RegWrite, bus.clear_busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_idle: got we=%b busy=%b expected 0 0", bus.RegWrite, bus.clear_busy);
    end
  endtask

  task automatic test_single_write();
    drive(0, 1, 5'd3, 32'h1234, 0, 0, 0, 0);
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if ({bus.RegWrite, bus.write_address, bus.write_data} !== {1'b1, 5'd3, 32'h1234}) begin
      miscompares++;
      $display("FAIL single_write: got we=%b addr=%h data=%h expected 1 03 00001234",
               bus.RegWrite, bus.write_address, bus.write_data);
    end
    tick();
    vectors++;
    if ({bus.RegWrite, bus.write_address, bus.write_data} !== {1'b0, 5'd3, 32'h1234}) begin
      miscompares++;
      $display("FAIL single_hold: got we=%b addr=%h data=%h expected 0 03 00001234",
               bus.RegWrite, bus.write_address, bus.write_data);
    end
  endtask

  task automatic test_round_robin();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 1, 5'd1, 32'hA, 1, 5'd2, 32'hB, 0);
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", i, {bus.req0_ready, bus.req1_ready},
                 ((i % 2 == 0) ? 2'b10 : 2'b01));
      end
      tick();
      vectors++;
      if ({bus.RegWrite, bus.write_address, bus.write_data} !==
          ((i % 2 == 0) ? {1'b1, 5'd1, 32'hA} : {1'b1, 5'd2, 32'hB})) begin
        miscompares++;
        $display("FAIL rr_write[%0d]: got we=%b addr=%h data=%h", i, bus.RegWrite, bus.write_address, bus.write_data);
      end
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_lone_then_contention();
    drive(0, 0, 0, 0, 1, 5'd7, 32'h77, 0);
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL lone_grant: got %b expected 01", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    drive(0, 1, 5'd9, 32'h99, 1, 5'd7, 32'h71, 0);
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL contend_first: got %b expected 10", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    vectors++;
    if ({bus.RegWrite, bus.write_address, bus.write_data} !== {1'b1, 5'd9, 32'h99}) begin
      miscompares++;
      $display("FAIL contend_write0: got we=%b addr=%h data=%h expected 1 09 00000099",
               bus.RegWrite, bus.write_address, bus.write_data);
    end
    drive(0, 1, 5'd10, 32'haa, 1, 5'd7, 32'h71, 0);
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL contend_second: got %b expected 01", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    vectors++;
    if ({bus.RegWrite, bus.write_address, bus.write_data} !== {1'b1, 5'd7, 32'h71}) begin
      miscompares++;
      $display("FAIL contend_write1: got we=%b addr=%h data=%h expected 1 07 00000071",
               bus.RegWrite, bus.write_address, bus.write_data);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_clear_vs_request();
    drive(0, 0, 0, 0, 1, 5'd5, 32'h55, 1);
    #1;
    vectors++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL clr_req_ready: got %b expected 00", {bus.req0_ready, bus.req1_ready});
    end
    tick();
    drive(0, 0, 0, 0, 1, 5'd5, 32'h55, 0);
    vectors++;
    if ({bus.RegWrite, bus.clear_busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL clr_enter: got we=%b busy=%b expected 0 1", bus.RegWrite, bus.clear_busy);
    end
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      vectors++;
      if ({bus.clear_busy, bus.req0_ready, bus.req1_ready} !== 3'b100) begin
        miscompares++;
        $display("FAIL clr_busy[%0d]: got busy/r0/r1=%b expected 100", i,
                 {bus.clear_busy, bus.req0_ready, bus.req1_ready});
      end
      tick();
      vectors++;
      if ({bus.RegWrite, bus.write_address, bus.write_data} !== {1'b1, SW'(i), 32'd0}) begin
        miscompares++;
        $display("FAIL clr_write[%0d]: got we=%b addr=%h data=%h expected 1 %h 0", i,
                 bus.RegWrite, bus.write_address, bus.write_data, SW'(i));
      end
    end
    #1;
    vectors++;
    if ({bus.clear_busy, bus.req0_ready, bus.req1_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL clr_exit_grant: got busy/r0/r1=%b expected 001", {bus.clear_busy, bus.req0_ready, bus.req1_ready});
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    vectors++;
    if ({bus.RegWrite, bus.write_address, bus.write_data} !== {1'b1, 5'd5, 32'h55}) begin
      miscompares++;
      $display("FAIL clr_pending_write: got we=%b addr=%h data=%h expected 1 05 00000055",
               bus.RegWrite, bus.write_address, bus.write_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick();
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    tick();
    vectors++;
    if ({bus.RegWrite, bus.clear_busy, bus.write_address} !== {1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL midclr_reset: got we=%b busy=%b addr=%h expected 0 0 00",
               bus.RegWrite, bus.clear_busy, bus.write_address);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    vectors++;
    if ({bus.RegWrite, bus.clear_busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL midclr_abandoned: got we=%b busy=%b expected 0 0", bus.RegWrite, bus.clear_busy);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      vectors++;
      if ({bus.RegWrite, bus.write_address, bus.write_data} !== {1'b1, SW'(i), 32'd0}) begin
        miscompares++;
        $display("FAIL midclr_restart[%0d]: got we=%b addr=%h data=%h", i,
                 bus.RegWrite, bus.write_address, bus.write_data);
      end
    end
    vectors++;
    if (bus.clear_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL midclr_done: got busy=%b expected 0", bus.clear_busy);
    end
  endtask

  task automatic test_redundant_clear();
    int busy_cnt  = 0;
    int write_cnt = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    for (int c = 0; c < DEPTH + 8; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0, (c == 1 || c == 5));
      if (bus.clear_busy === 1'b1) busy_cnt++;
      tick();
      if (bus.RegWrite === 1'b1) begin
        vectors++;
        if (bus.write_address !== SW'(write_cnt) || bus.write_data !== 32'd0) begin
          miscompares++;
          $display("FAIL redun_write[%0d]: got addr=%h data=%h expected %h 0", write_cnt,
                   bus.write_address, bus.write_data, SW'(write_cnt));
        end
        write_cnt++;
      end
    end
    vectors++;
    if (write_cnt != DEPTH || busy_cnt != DEPTH) begin
      miscompares++;
      $display("FAIL redun_counts: got writes=%0d busy=%0d expected %0d %0d", write_cnt, busy_cnt, DEPTH, DEPTH);
    end
  endtask

  task automatic test_random();
    bit              p0v = 0, p1v = 0, g0, g1;
    logic [SW-1:0]   p0a = '0, p1a = '0;
    logic [DW-1:0]   p0d = '0, p1d = '0;
    bit              r, cs;
    for (int c = 0; c < 600; c++) begin
      r  = ($urandom_range(63) == 0);
      cs = ($urandom_range(39) == 0);
      if (!p0v && $urandom_range(1) == 1) begin p0v = 1; p0a = SW'($urandom); p0d = $urandom; end
      if (!p1v && $urandom_range(1) == 1) begin p1v = 1; p1a = SW'($urandom); p1d = $urandom; end
      drive(r, p0v, p0a, p0d, p1v, p1a, p1d, cs);
      #1;
      exp_grant(g0, g1);
      vectors++;
      if ({bus.req0_ready, bus.req1_ready} !== {g0, g1}) begin
        miscompares++;
        $display("FAIL rand_ready[%0d]: got %b expected %b", c, {bus.req0_ready, bus.req1_ready}, {g0, g1});
      end
      tick();
      if (tg0) p0v = 0;
      if (tg1) p1v = 0;
      vectors++;
      if ({bus.RegWrite, bus.clear_busy, bus.write_address, bus.write_data} !==
          {m_we, (m_clr_left > 0), m_addr, m_data}) begin
        miscompares++;
        $display("FAIL rand_out[%0d]: got we=%b busy=%b addr=%h data=%h expected %b %b %h %h", c,
                 bus.RegWrite, bus.clear_busy, bus.write_address, bus.write_data,
                 m_we, (m_clr_left > 0), m_addr, m_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_lone_then_contention();
    test_clear_vs_request();
    test_reset_mid_clear();
    test_redundant_clear();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
